// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller for the 4-digit HH:MM seven-segment display.
// A coherent BCD snapshot is captured on load and shown one digit per slot.
// Each slot begins with a short dead time where all anodes are off, which
// keeps the previous digit from ghosting onto the next one. A slot can be
// blanked for three reasons: an invalid BCD code, the blink-off phase of a
// digit being set, or a leading zero on the hour tens digit. The colon is
// lit on slot 2 during the blink-on phase.

module display_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic [3:0]  blink_mask,
    input  logic        blank_lead,
    output logic [3:0]  digit_out,
    output logic [3:0]  anodos,
    output logic        dp_n
);

    localparam int PW = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = ($clog2(BLINK_DIV) > 0) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    slot_t          slot;
    slot_t          slot_nx;
    logic [PW-1:0]  presc;
    logic [PW-1:0]  presc_nx;
    logic [BW-1:0]  blink_cnt;
    logic [BW-1:0]  blink_cnt_nx;
    logic           phase;
    logic           phase_nx;
    logic           blanked;
    logic           blank_nx;
    logic [15:0]    snapshot;
    logic           tick;
    logic [1:0]     idx_nx;
    logic [3:0]     nibble;
    logic [3:0]     digit_nx;
    logic [3:0]     anodos_nx;
    logic           dp_nx;
    logic           in_guard_nx;
    int             presc_nx_i;

    // Next-state view of the scan: where the prescaler, slot and blink phase
    // will be after this edge, and what the outputs must look like there.
    // Digit and blank decisions are taken only when entering a new slot so
    // they stay constant for the whole slot; the snapshot used is the one
    // held before the edge, so a load on a boundary shows up one slot later.
    always_comb begin
        tick         = (presc == PRESC_MAX);
        presc_nx     = tick ? '0 : presc + PW'(1);
        presc_nx_i   = int'(presc_nx);
        in_guard_nx  = (presc_nx_i < GUARD);

        slot_nx = slot;
        if (tick) begin
            case (slot)
                SLOT0:   slot_nx = SLOT1;
                SLOT1:   slot_nx = SLOT2;
                SLOT2:   slot_nx = SLOT3;
                default: slot_nx = SLOT0;
            endcase
        end
        idx_nx = slot_nx;

        blink_cnt_nx = blink_cnt;
        phase_nx     = phase;
        if (tick) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt_nx = '0;
                phase_nx     = ~phase;
            end else begin
                blink_cnt_nx = blink_cnt + BW'(1);
            end
        end

        case (slot_nx)
            SLOT0:   nibble = snapshot[3:0];
            SLOT1:   nibble = snapshot[7:4];
            SLOT2:   nibble = snapshot[11:8];
            default: nibble = snapshot[15:12];
        endcase

        blank_nx = blanked;
        digit_nx = digit_out;
        if (tick) begin
            blank_nx = (nibble > 4'd9)
                    || (blink_mask[idx_nx] && !phase_nx)
                    || ((slot_nx == SLOT3) && blank_lead && (nibble == 4'd0));
            digit_nx = blank_nx ? 4'd0 : nibble;
        end

        anodos_nx = (in_guard_nx || blank_nx) ? 4'b1111 : ~(4'b0001 << idx_nx);
        dp_nx     = !((slot_nx == SLOT2) && !in_guard_nx && phase_nx);
    end

    // Scan state, snapshot and all display outputs, registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot      <= SLOT0;
            presc     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            blanked   <= 1'b0;
            snapshot  <= 16'h0000;
            digit_out <= 4'd0;
            anodos    <= 4'b1111;
            dp_n      <= 1'b1;
        end else begin
            slot      <= slot_nx;
            presc     <= presc_nx;
            blink_cnt <= blink_cnt_nx;
            phase     <= phase_nx;
            blanked   <= blank_nx;
            if (load) begin
                snapshot <= digits_in;
            end
            digit_out <= digit_nx;
            anodos    <= anodos_nx;
            dp_n      <= dp_nx;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display of the clock design.
- Latches a coherent BCD snapshot (HH:MM) from the timekeeping logic and rotates one digit at a time onto the shared BCD-to-segment encoder input.
- Drives active-low digit anodes with a dead-time guard, digit blinking for set mode, tens-of-hours leading-zero blanking and a blinking colon.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot, legal range 2..2^20.
- GUARD, 16: clocks at the start of each slot with all anodes off (anti-ghosting), legal range 0..SCAN_DIV-1.
- BLINK_DIV, 125: digit slots per blink half-period, legal range 1..1023.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- digits_in  input  16  BCD digits; [15:12]=hour tens (slot 3), [11:8]=hour units (slot 2), [7:4]=minute tens (slot 1), [3:0]=minute units (slot 0).
- load  input  1  single-cycle strobe; captures digits_in into the snapshot.
- blink_mask  input  4  bit i=1 makes slot i blink.
- blank_lead  input  1  1 = blank slot 3 when its digit is 0.
- digit_out  output  4  BCD value to the segment encoder; always 0..9.
- anodos  output  4  active-low digit enables, bit i = slot i.
- dp_n  output  1  active-low colon/decimal point, asserted only on slot 2.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (applied immediately, held while reset=1):
  - anodos=4'b1111, digit_out=0, dp_n=1.
  - Slot index=0, prescaler=0, blink counter=0, blink phase=ON(1), snapshot=16'h0000.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted on the cycle the count equals SCAN_DIV-1.
- Slot FSM:
  - States SLOT0->SLOT1->SLOT2->SLOT3->SLOT0, advancing on tick.
  - Slot boundary = the cycle after tick.
- Snapshot:
  - On load, snapshot<=digits_in on the next edge.
  - digit_out is registered from the snapshot only at a slot boundary, so a value never changes mid-slot.
  - load coincident with a boundary edge: the old snapshot feeds that slot; the new value is used from the following slot.
- Guard phase: prescaler < GUARD -> anodos=4'b1111. digit_out is already updated during guard.
- Drive phase: prescaler >= GUARD -> anodos has only bit[index]=0, unless the slot is blanked.
- Slot blanked (anodos all 1, digit_out forced 0) when any of:
  - The snapshot nibble is >9 (the encoder output for such codes is undefined and must never be displayed).
  - blink_mask[index]=1 and blink phase=OFF.
  - index=3, blank_lead=1 and the nibble is 0.
  - Blanking is evaluated at the slot boundary with the registered inputs and held for the whole slot.
- Blink:
  - Counter increments on every tick.
  - At BLINK_DIV-1 it wraps to 0 and toggles the blink phase.
  - blink_mask=0 -> no effect.
- Colon: dp_n=0 when index=2, in the drive phase, and blink phase=ON; otherwise 1. The colon is independent of blanking of slot 2.
- Latency:
  - Display-visible latency from load is at most 1 + SCAN_DIV*4 + GUARD cycles.
  - Outputs are fully registered, so there are no combinational paths from inputs to outputs.
- Reset mid-slot: outputs return to reset values immediately (asynchronous); the scan restarts in SLOT0 at prescaler 0 after deassertion.

Test Plan (SCAN_DIV=4, GUARD=1, BLINK_DIV=2 unless noted):
- Reset release with no load -> anodos=1111 for 1 clk, then per slot: 1 clk of 1111 followed by 3 clk of 1110/1101/1011/0111 in turn; digit_out=0 in each slot; period 16 clk.
- load with digits_in=16'h1234 -> after the next boundary, digit_out follows 4,3,2,1 on slots 0..3; dp_n=0 for 3 clk in slot 2 only while blink phase=ON.
- digits_in=16'h0959, blank_lead=1 -> slot 3 anodos=1111, digit_out=0. With blank_lead=0 -> slot 3 enabled with digit_out=0.
- blink_mask=4'b0011 -> slots 0/1 are enabled for 2 slots and blanked for 2 slots, alternating; slots 2/3 are unaffected.
- digits_in=16'h12A4 -> slot 1 is blanked with digit_out=0; the other slots are normal.
- load asserted on the boundary edge -> the current slot shows the old digit and the next slot shows the new one. Reset asserted mid-drive -> anodos=1111 and digit_out=0 in the same cycle.
